// File: rtl/clock_mode_ctrl.sv
// Mode controller for the clock-mode time counter: run / time-set / commit / alarm-set,
// alarm storage and ring detection. Optional auto-silence timer under AUTO_SILENCE_EN.
module clock_mode_ctrl #(
  parameter int unsigned LOAD_HOLD    = 100000000,
  parameter logic [39:0] RING_TIMEOUT = 40'd6000000000
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       btn_mode,
  input  logic       btn_next,
  input  logic       btn_up,
  input  logic       btn_down,
  input  logic [3:0] cur_min_units,
  input  logic [2:0] cur_min_tens,
  input  logic [3:0] cur_hour_units,
  input  logic [2:0] cur_hour_tens,
  output logic       run_en,
  output logic       load_out,
  output logic [5:0] time_mins,
  output logic [4:0] time_hrs,
  output logic [5:0] alarm_mins,
  output logic [4:0] alarm_hrs,
  output logic [1:0] mode,
  output logic       field_sel,
  output logic       alarm_armed,
  output logic       ringing
);

  typedef enum logic [1:0] {
    CLOCK     = 2'd0,
    SET_TIME  = 2'd1,
    SET_ALARM = 2'd2,
    COMMIT    = 2'd3
  } state_t;

  state_t      state;
  logic [31:0] hold_cnt;
  logic        match_d;
  logic [4:0]  cur_hrs;
  logic [5:0]  cur_mins;
  logic        match;
  logic        any_btn;
  logic        ring_start;

  if (LOAD_HOLD == 0) begin : g_load_hold_chk
    $error("LOAD_HOLD must be at least 1");
  end
  if (RING_TIMEOUT == 40'd0) begin : g_ring_timeout_chk
    $error("RING_TIMEOUT must be at least 1");
  end

  function automatic logic [4:0] hrs_step(input logic [4:0] v, input logic up);
    if (up) return (v == 5'd23) ? 5'd0 : v + 5'd1;
    return (v == 5'd0) ? 5'd23 : v - 5'd1;
  endfunction

  function automatic logic [5:0] mins_step(input logic [5:0] v, input logic up);
    if (up) return (v == 6'd59) ? 6'd0 : v + 6'd1;
    return (v == 6'd0) ? 6'd59 : v - 6'd1;
  endfunction

  assign cur_hrs    = 5'(cur_hour_tens) * 5'd10 + 5'(cur_hour_units);
  assign cur_mins   = 6'(cur_min_tens) * 6'd10 + 6'(cur_min_units);
  assign match      = (alarm_hrs == cur_hrs) && (alarm_mins == cur_mins);
  assign any_btn    = btn_mode | btn_next | btn_up | btn_down;
  assign ring_start = (state == CLOCK) && alarm_armed && match && !match_d;
  assign mode       = state;

`ifdef AUTO_SILENCE_EN
  logic [39:0] ring_cnt;
`endif

  always_ff @(posedge clk) begin
    if (reset) begin
      state       <= CLOCK;
      run_en      <= 1'b1;
      load_out    <= 1'b0;
      time_mins   <= '0;
      time_hrs    <= '0;
      alarm_mins  <= '0;
      alarm_hrs   <= '0;
      field_sel   <= 1'b0;
      alarm_armed <= 1'b0;
      ringing     <= 1'b0;
      hold_cnt    <= '0;
      match_d     <= 1'b0;
`ifdef AUTO_SILENCE_EN
      ring_cnt    <= '0;
`endif
    end else begin
      match_d <= match;
      // A press while ringing only silences; it never reaches the mode logic.
      if (ringing && any_btn) begin
        ringing <= 1'b0;
      end else begin
        case (state)
          CLOCK: begin
            run_en <= 1'b1;
            if (btn_mode) begin
              state     <= SET_TIME;
              run_en    <= 1'b0;
              time_hrs  <= cur_hrs;
              time_mins <= cur_mins;
              field_sel <= 1'b0;
            end else if (btn_next) begin
              alarm_armed <= ~alarm_armed;
            end
          end
          SET_TIME: begin
            run_en <= 1'b0;
            if (btn_mode) begin
              state    <= COMMIT;
              load_out <= 1'b1;
              hold_cnt <= '0;
            end else if (btn_next) begin
              field_sel <= ~field_sel;
            end else if (btn_up || btn_down) begin
              if (field_sel) time_mins <= mins_step(time_mins, btn_up);
              else           time_hrs  <= hrs_step(time_hrs, btn_up);
            end
          end
          COMMIT: begin
            // Load stays asserted long enough for the divided counter clock to see it.
            run_en <= 1'b0;
            if (hold_cnt == LOAD_HOLD - 1) begin
              state     <= SET_ALARM;
              load_out  <= 1'b0;
              field_sel <= 1'b0;
              run_en    <= 1'b1;
              hold_cnt  <= '0;
            end else begin
              hold_cnt <= hold_cnt + 32'd1;
            end
          end
          SET_ALARM: begin
            run_en <= 1'b1;
            if (btn_mode) begin
              state <= CLOCK;
            end else if (btn_next) begin
              field_sel <= ~field_sel;
            end else if (btn_up || btn_down) begin
              if (field_sel) alarm_mins <= mins_step(alarm_mins, btn_up);
              else           alarm_hrs  <= hrs_step(alarm_hrs, btn_up);
            end
          end
          default: state <= CLOCK;
        endcase
      end
`ifdef AUTO_SILENCE_EN
      if (ring_start || any_btn) begin
        ring_cnt <= '0;
      end else if (ringing) begin
        if (ring_cnt == RING_TIMEOUT - 40'd1) ringing <= 1'b0;
        else                                  ring_cnt <= ring_cnt + 40'd1;
      end
`endif
      if (ring_start) ringing <= 1'b1;
    end
  end

endmodule

// File: tb/tb_clock_mode_ctrl.sv
// Directed bench for clock_mode_ctrl with LOAD_HOLD=4, RING_TIMEOUT=10.
module tb_clock_mode_ctrl;

  logic       clk = 1'b0;
  logic       reset = 1'b1;
  logic       btn_mode = 1'b0, btn_next = 1'b0, btn_up = 1'b0, btn_down = 1'b0;
  logic [3:0] cur_min_units = '0;
  logic [2:0] cur_min_tens = '0;
  logic [3:0] cur_hour_units = '0;
  logic [2:0] cur_hour_tens = '0;
  logic       run_en, load_out;
  logic [5:0] time_mins, alarm_mins;
  logic [4:0] time_hrs, alarm_hrs;
  logic [1:0] mode;
  logic       field_sel, alarm_armed, ringing;

  int pass = 0;
  int total = 0;

  clock_mode_ctrl #(.LOAD_HOLD(4), .RING_TIMEOUT(40'd10)) dut (
    .clk(clk), .reset(reset),
    .btn_mode(btn_mode), .btn_next(btn_next), .btn_up(btn_up), .btn_down(btn_down),
    .cur_min_units(cur_min_units), .cur_min_tens(cur_min_tens),
    .cur_hour_units(cur_hour_units), .cur_hour_tens(cur_hour_tens),
    .run_en(run_en), .load_out(load_out),
    .time_mins(time_mins), .time_hrs(time_hrs),
    .alarm_mins(alarm_mins), .alarm_hrs(alarm_hrs),
    .mode(mode), .field_sel(field_sel), .alarm_armed(alarm_armed), .ringing(ringing)
  );

  always #5 clk = ~clk;

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout want finish");
    $fatal(1, "watchdog expired");
  end

  // b = {mode, next, up, down}; asserted for one cycle, returns at the following negedge.
  task automatic press(input logic [3:0] b);
    @(negedge clk);
    {btn_mode, btn_next, btn_up, btn_down} = b;
    @(negedge clk);
    {btn_mode, btn_next, btn_up, btn_down} = 4'b0000;
  endtask

  task automatic set_digits(input int h, input int m);
    cur_hour_tens  = 3'(h / 10);
    cur_hour_units = 4'(h % 10);
    cur_min_tens   = 3'(m / 10);
    cur_min_units  = 4'(m % 10);
  endtask

  task automatic test_reset;
    reset = 1'b1;
    repeat (3) @(negedge clk);
    reset = 1'b0;
    repeat (3) @(negedge clk);
    total++; if (mode !== 2'd0) $display("FAIL rst_mode: got %0d want 0", mode); else pass++;
    total++; if (run_en !== 1'b1) $display("FAIL rst_run_en: got %0b want 1", run_en); else pass++;
    total++; if (load_out !== 1'b0) $display("FAIL rst_load: got %0b want 0", load_out); else pass++;
    total++; if ({alarm_hrs, alarm_mins} !== 11'd0) $display("FAIL rst_alarm: got %0d:%0d want 0:0", alarm_hrs, alarm_mins); else pass++;
    total++; if (ringing !== 1'b0) $display("FAIL rst_ringing: got %0b want 0", ringing); else pass++;
    total++; if (alarm_armed !== 1'b0) $display("FAIL rst_armed: got %0b want 0", alarm_armed); else pass++;
  endtask

  task automatic test_set_time;
    set_digits(13, 45);
    press(4'b1000);
    total++; if (mode !== 2'd1) $display("FAIL st_mode: got %0d want 1", mode); else pass++;
    total++; if (run_en !== 1'b0) $display("FAIL st_run_en: got %0b want 0", run_en); else pass++;
    total++; if (time_hrs !== 5'd13) $display("FAIL st_pre_hrs: got %0d want 13", time_hrs); else pass++;
    total++; if (time_mins !== 6'd45) $display("FAIL st_pre_mins: got %0d want 45", time_mins); else pass++;
    press(4'b0100);
    total++; if (field_sel !== 1'b1) $display("FAIL st_field: got %0b want 1", field_sel); else pass++;
    repeat (15) press(4'b0010);
    total++; if (time_mins !== 6'd0) $display("FAIL st_min_wrap: got %0d want 0", time_mins); else pass++;
    total++; if (time_hrs !== 5'd13) $display("FAIL st_no_carry: got %0d want 13", time_hrs); else pass++;
    press(4'b0100);
    repeat (13) press(4'b0001);
    total++; if (time_hrs !== 5'd0) $display("FAIL st_hrs_down: got %0d want 0", time_hrs); else pass++;
    press(4'b0001);
    total++; if (time_hrs !== 5'd23) $display("FAIL st_hrs_wrap: got %0d want 23", time_hrs); else pass++;
  endtask

  task automatic test_commit;
    int cnt;
    press(4'b1000);
    total++; if (mode !== 2'd3) $display("FAIL cm_mode: got %0d want 3", mode); else pass++;
    cnt = (load_out === 1'b1) ? 1 : 0;
    for (int i = 0; i < 8; i++) begin
      btn_up = (i < 3);
      @(negedge clk);
      if (load_out === 1'b1) cnt++;
    end
    btn_up = 1'b0;
    total++; if (cnt !== 4) $display("FAIL cm_load_len: got %0d want 4", cnt); else pass++;
    total++; if (mode !== 2'd2) $display("FAIL cm_exit_mode: got %0d want 2", mode); else pass++;
    total++; if ({time_hrs, time_mins} !== {5'd23, 6'd0}) $display("FAIL cm_held: got %0d:%0d want 23:0", time_hrs, time_mins); else pass++;
    total++; if ({field_sel, run_en} !== 2'b01) $display("FAIL cm_field_run: got %0b want 01", {field_sel, run_en}); else pass++;
    total++; if (alarm_hrs !== 5'd0) $display("FAIL cm_alarm_untouched: got %0d want 0", alarm_hrs); else pass++;
  endtask

  task automatic test_alarm;
    repeat (6) press(4'b0010);
    press(4'b0100);
    repeat (30) press(4'b0010);
    total++; if ({alarm_hrs, alarm_mins} !== {5'd6, 6'd30}) $display("FAIL al_value: got %0d:%0d want 6:30", alarm_hrs, alarm_mins); else pass++;
    set_digits(6, 29);
    press(4'b1000);
    total++; if (mode !== 2'd0) $display("FAIL al_to_clock: got %0d want 0", mode); else pass++;
    press(4'b0100);
    total++; if (alarm_armed !== 1'b1) $display("FAIL al_armed: got %0b want 1", alarm_armed); else pass++;
    set_digits(6, 30);
    total++; if (ringing !== 1'b0) $display("FAIL al_not_yet: got %0b want 0", ringing); else pass++;
    @(negedge clk);
    total++; if (ringing !== 1'b1) $display("FAIL al_ring: got %0b want 1", ringing); else pass++;
    repeat (3) @(negedge clk);
    total++; if (ringing !== 1'b1) $display("FAIL al_ring_hold: got %0b want 1", ringing); else pass++;
    press(4'b0010);
    total++; if (ringing !== 1'b0) $display("FAIL al_silence: got %0b want 0", ringing); else pass++;
    total++; if (time_hrs !== 5'd23) $display("FAIL al_consumed: got %0d want 23", time_hrs); else pass++;
    repeat (5) @(negedge clk);
    total++; if (ringing !== 1'b0) $display("FAIL al_no_refire: got %0b want 0", ringing); else pass++;
  endtask

  task automatic test_ring_duration;
    int cnt;
    set_digits(6, 31);
    @(negedge clk);
    set_digits(6, 30);
    @(negedge clk);
    total++; if (ringing !== 1'b1) $display("FAIL rd_ring: got %0b want 1", ringing); else pass++;
`ifdef AUTO_SILENCE_EN
    cnt = 1;
    for (int i = 0; i < 30; i++) begin
      @(negedge clk);
      if (ringing === 1'b1) cnt++;
    end
    total++; if (cnt !== 10) $display("FAIL rd_auto_len: got %0d want 10", cnt); else pass++;
    total++; if (ringing !== 1'b0) $display("FAIL rd_auto_off: got %0b want 0", ringing); else pass++;
`else
    cnt = 0;
    repeat (1000) @(negedge clk);
    total++; if (ringing !== 1'b1) $display("FAIL rd_persist: got %0b want 1", ringing); else pass++;
    press(4'b1100);
    total++; if (ringing !== 1'b0) $display("FAIL rd_silence: got %0b want 0", ringing); else pass++;
    total++; if ({mode, alarm_armed} !== 3'b001) $display("FAIL rd_consumed: got %0b want 001", {mode, alarm_armed}); else pass++;
`endif
  endtask

  task automatic test_priority;
    set_digits(13, 45);
    @(negedge clk);
    press(4'b1010);
    total++; if (mode !== 2'd1) $display("FAIL pr_mode: got %0d want 1", mode); else pass++;
    total++; if ({time_hrs, time_mins} !== {5'd13, 6'd45}) $display("FAIL pr_preload: got %0d:%0d want 13:45", time_hrs, time_mins); else pass++;
    total++; if (field_sel !== 1'b0) $display("FAIL pr_field0: got %0b want 0", field_sel); else pass++;
    press(4'b0110);
    total++; if ({field_sel, time_mins} !== {1'b1, 6'd45}) $display("FAIL pr_next_over_up: got %0b/%0d want 1/45", field_sel, time_mins); else pass++;
    press(4'b0011);
    total++; if (time_mins !== 6'd46) $display("FAIL pr_up_over_down: got %0d want 46", time_mins); else pass++;
  endtask

  task automatic test_reset_in_commit;
    press(4'b1000);
    total++; if (load_out !== 1'b1) $display("FAIL rc_load: got %0b want 1", load_out); else pass++;
    reset = 1'b1;
    @(negedge clk);
    reset = 1'b0;
    total++; if ({mode, load_out, run_en} !== 4'b0001) $display("FAIL rc_reset: got %0b want 0001", {mode, load_out, run_en}); else pass++;
  endtask

  initial begin
    test_reset;
    test_set_time;
    test_commit;
    test_alarm;
    test_ring_duration;
    test_priority;
    test_reset_in_commit;
    $display("%0d/%0d checks passed", pass, total);
    $finish;
  end

endmodule

// File: doc/clock_mode_ctrl.md
Name: clock_mode_ctrl

Overview:
- Mode controller and scheduler for the clock-mode time counter.
- Sequences three modes: normal run, time-set and alarm-set.
- Drives the counter's enable and load inputs, including the preset minutes and hours values; holds the load long enough for the counter's divided clock to sample it.
- Stores the alarm time, compares it against the live counter digits and raises the ring output.

Parameters:
LOAD_HOLD, 100000000, clk cycles load_out is held in COMMIT (must be at least one divided-clock period)
RING_TIMEOUT, 6000000000, clk cycles before auto-silence (used only with AUTO_SILENCE_EN); minimum width 33 bits

Ports:
clk  in  1  system clock
reset  in  1  synchronous, active-high reset
btn_mode  in  1  single-cycle pulse (debounced upstream): advance mode
btn_next  in  1  pulse: toggle edit field / toggle alarm arm
btn_up  in  1  pulse: increment selected field
btn_down  in  1  pulse: decrement selected field
cur_min_units  in  4  live counter minute units
cur_min_tens  in  3  live counter minute tens
cur_hour_units  in  4  live counter hour units
cur_hour_tens  in  3  live counter hour tens
run_en  out  1  counter enable
load_out  out  1  counter load strobe (held)
time_mins  out  6  preset minutes, 0..59
time_hrs  out  5  preset hours, 0..23
alarm_mins  out  6  stored alarm minutes
alarm_hrs  out  5  stored alarm hours
mode  out  2  0=CLOCK, 1=SET_TIME, 2=SET_ALARM, 3=COMMIT
field_sel  out  1  0=hours, 1=minutes being edited
alarm_armed  out  1  alarm enabled
ringing  out  1  alarm active

Behaviour:
- Reset values: mode=CLOCK, run_en=1, load_out=0, time_mins=0, time_hrs=0, alarm_mins=0, alarm_hrs=0, field_sel=0, alarm_armed=0, ringing=0, hold counter=0. Reset mid-COMMIT drops load_out on the next edge.
- Button priority within one cycle: mode > next > up > down. Only the highest-priority pulse acts; the others are dropped.
- All outputs are registered. Every transition and edit takes effect one clk after the pulse.
- CLOCK:
  - run_en=1.
  - btn_mode -> SET_TIME. Also preloads time_hrs = cur_hour_tens*10 + cur_hour_units, time_mins = cur_min_tens*10 + cur_min_units, and sets field_sel=0.
  - btn_next toggles alarm_armed.
- SET_TIME:
  - run_en=0.
  - btn_next toggles field_sel.
  - btn_up / btn_down adjust the selected register with wrap: hours 23->0 and 0->23; minutes 59->0 and 0->59. No carry between fields.
  - btn_mode -> COMMIT.
- COMMIT:
  - run_en=0, load_out=1 for exactly LOAD_HOLD cycles; time_* are held stable.
  - All buttons are ignored.
  - On expiry: load_out=0, field_sel=0, mode -> SET_ALARM.
- SET_ALARM:
  - run_en=1.
  - btn_next, btn_up and btn_down act on alarm_hrs / alarm_mins with the same wrap rules.
  - btn_mode -> CLOCK.
- Match:
  - match = (alarm_hrs == cur hours) & (alarm_mins == cur minutes), decoded from the digits.
  - Registered match_d.
  - ringing is set on the cycle after (mode==CLOCK & alarm_armed & match & !match_d).
  - Fires once per match minute. An alarm set equal to the current time does not fire until the next occurrence.
- Silencing:
  - While ringing=1, any button pulse clears ringing and is consumed (no mode, arm or edit effect).
  - Clearing alarm_armed is impossible while ringing, because the press is consumed.
  - Leaving CLOCK does not occur while ringing, for the same reason.

Optional Feature:
AUTO_SILENCE_EN
- Defined: a counter starts when ringing sets. ringing clears automatically after RING_TIMEOUT cycles; a button press clears it earlier and resets the counter. No re-fire in the same minute (edge detect).
- Undefined: ringing persists until a button press; no counter logic is synthesised.

Test Plan:
- Bench overrides LOAD_HOLD=4 and RING_TIMEOUT=10.
- Reset, then idle -> mode=0, run_en=1, load_out=0, alarm 00:00, ringing=0.
- Digits 1,3 : 4,5 (13:45), btn_mode -> mode=1, run_en=0, time_hrs=13, time_mins=45. btn_next, btn_up x15 -> time_mins=0, time_hrs=13 (wrap, no carry).
- In SET_TIME at hrs=0, btn_down -> hrs=23. btn_mode -> load_out=1 for exactly 4 cycles; btn_up pulses during COMMIT ignored; then mode=2, load_out=0.
- SET_ALARM to 06:30, btn_mode, btn_next (armed=1). Digits step 06:29 -> 06:30 -> ringing=1 one cycle later. btn_up -> ringing=0, time_hrs unchanged. Digits held at 06:30 -> no re-fire.
- Same cycle btn_mode + btn_up in CLOCK -> only mode change (mode=1); edit registers equal the preload.
- With AUTO_SILENCE_EN: alarm fires -> ringing drops after 10 cycles with no button. Without AUTO_SILENCE_EN: ringing still 1 after 1000 cycles.
